// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Latency: request accepted at the end of the grant cycle; response valid two edges later (3-cycle op at full rate).
// Backpressure: result and flags held until the owner asserts rsp_ready; no new request is taken while busy.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready [1:0]       per-requester request handshake (req_ready one-hot or zero)
//   req_op0/1, req_a0/1, req_b0/1   per-requester ALU control code and operands
//   rsp_valid/rsp_ready [1:0]       per-requester response handshake (rsp_valid one-hot or zero)
//   rsp_data, rsp_zero, rsp_carry   captured ALU result and flags (shared)
//   alu_in_a, alu_in_b, alu_control operand/control registers driven to the ALU
//   alu_out, alu_zero, alu_carry    ALU result and flags
//   grant_cnt0/1                    saturating accepted-request counters
//   busy                            high whenever an operation is in flight
// Build option: define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win a tie.

module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req_op0,
  input  logic [3:0]       req_op1,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_b1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic [31:0]      alu_in_a,
  output logic [31:0]      alu_in_b,
  output logic [3:0]       alu_control,
  input  logic [31:0]      alu_out,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]  state;
  logic        owner;
  logic        last_grant;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        grant_id;
  logic        accept;

  // Winner selection; only meaningful when at least one request is valid.
  always_comb begin
    grant_id = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking.
    grant_id = ~req_valid[0];
`else
    if (&req_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req_valid[1];
    end
`endif
  end

  always_comb begin
    accept    = (state == IDLE) && (|req_valid);
    req_ready = 2'b00;
    if (accept) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
    rsp_valid = 2'b00;
    if (state == RESP) begin
      rsp_valid = owner ? 2'b10 : 2'b01;
    end
  end

  assign busy        = (state != IDLE);
  assign alu_in_a    = a_q;
  assign alu_in_b    = b_q;
  assign alu_control = op_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= 4'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      rsp_data   <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= grant_id;
            op_q  <= grant_id ? req_op1 : req_op0;
            a_q   <= grant_id ? req_a1  : req_a0;
            b_q   <= grant_id ? req_b1  : req_b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have been stable from the operand registers all cycle.
          rsp_data  <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_carry <= alu_carry;
          state     <= RESP;
        end
        RESP: begin
          // Only the owner's ready bit can retire the response.
          if (rsp_ready[owner]) begin
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating per-requester counts of accepted requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req_ready[0] && (grant_cnt0 != CNT_MAX)) begin
        grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      end
      if (req_ready[1] && (grant_cnt1 != CNT_MAX)) begin
        grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: randomized and directed requests, scoreboard-checked responses.
// Two instances share stimulus; the second uses 2-bit counters to exercise saturation.
// Each instance gets its own behavioural ALU built from the function below.

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [3:0]  req_op0 = 4'd0, req_op1 = 4'd0;
  logic [31:0] req_a0 = 32'd0, req_a1 = 32'd0, req_b0 = 32'd0, req_b1 = 32'd0;
  logic [1:0]  rsp_ready = 2'b00;

  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data, alu_in_a, alu_in_b, alu_out;
  logic        rsp_zero, rsp_carry, alu_zero, alu_carry, busy;
  logic [3:0]  alu_control;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic [1:0]  s_req_ready, s_rsp_valid;
  logic [31:0] s_rsp_data, s_alu_in_a, s_alu_in_b, s_alu_out;
  logic        s_rsp_zero, s_rsp_carry, s_alu_zero, s_alu_carry, s_busy;
  logic [3:0]  s_alu_control;
  logic [1:0]  s_grant_cnt0, s_grant_cnt1;

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, zero, result}. Codes without a function return operand a.
  function automatic logic [33:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [32:0] s;
    logic        c;
    c = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
      4'b0110: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: r = a;
    endcase
    return {c, (r == 32'd0), r};
  endfunction

  assign {alu_carry, alu_zero, alu_out}       = alu_f(alu_control, alu_in_a, alu_in_b);
  assign {s_alu_carry, s_alu_zero, s_alu_out} = alu_f(s_alu_control, s_alu_in_a, s_alu_in_b);

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_control(alu_control),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .busy(busy)
  );

  alu_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(s_rsp_data), .rsp_zero(s_rsp_zero), .rsp_carry(s_rsp_carry),
    .alu_in_a(s_alu_in_a), .alu_in_b(s_alu_in_b), .alu_control(s_alu_control),
    .alu_out(s_alu_out), .alu_zero(s_alu_zero), .alu_carry(s_alu_carry),
    .grant_cnt0(s_grant_cnt0), .grant_cnt1(s_grant_cnt1), .busy(s_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          owner;
    logic [31:0] data;
    logic        zero;
    logic        carry;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          m_last = 1;
  int          m_cnt[2] = '{0, 0};
  int          cyc = 0;
  logic [1:0]  hs = 2'b00;
  bit          was_rst = 1'b1;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    logic [1:0]  exp_rr;
    logic [1:0]  exp_rv;
    logic [33:0] r;
    int          win;
    exp_t        e;
    if (!rst_n) begin
      sb.delete();
      m_last  = 1;
      m_cnt   = '{0, 0};
      hs      = 2'b00;
      was_rst = 1'b1;
    end else begin
      cyc++;
      if (was_rst) begin
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_flags", {rsp_zero, rsp_carry}, 0);
        chk("reset_alu_a", alu_in_a, 0);
        chk("reset_alu_b", alu_in_b, 0);
        chk("reset_alu_ctl", alu_control, 0);
        was_rst = 1'b0;
      end
      // Arbiter is free exactly when nothing is outstanding.
      win    = 0;
      exp_rr = 2'b00;
      if (sb.size() == 0 && req_valid != 2'b00) begin
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          win = 0;
`else
          win = (m_last == 0) ? 1 : 0;
`endif
        end else begin
          win = req_valid[1] ? 1 : 0;
        end
        exp_rr = (win == 1) ? 2'b10 : 2'b01;
      end
      chk("req_ready", req_ready, exp_rr);
      chk("busy", busy, (sb.size() != 0));
      chk("grant_cnt0", grant_cnt0, sat(m_cnt[0], 65535));
      chk("grant_cnt1", grant_cnt1, sat(m_cnt[1], 65535));
      chk("sat_grant_cnt0", s_grant_cnt0, sat(m_cnt[0], 3));
      chk("sat_grant_cnt1", s_grant_cnt1, sat(m_cnt[1], 3));

      exp_rv = 2'b00;
      if (sb.size() != 0 && cyc >= sb[0].acc + 2) exp_rv = (sb[0].owner == 1) ? 2'b10 : 2'b01;
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 2'b00) begin
        chk("rsp_data", rsp_data, sb[0].data);
        chk("rsp_zero", rsp_zero, sb[0].zero);
        chk("rsp_carry", rsp_carry, sb[0].carry);
        if (rsp_ready[sb[0].owner]) begin
          m_last = sb[0].owner;
          void'(sb.pop_front());
        end
      end

      hs = req_valid & req_ready;
      if (exp_rr != 2'b00) begin
        r       = (win == 1) ? alu_f(req_op1, req_a1, req_b1) : alu_f(req_op0, req_a0, req_b0);
        e.owner = win;
        e.data  = r[31:0];
        e.zero  = r[32];
        e.carry = r[33];
        e.acc   = cyc;
        sb.push_back(e);
        m_cnt[win]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (i == 0) begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
    end else begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
    end
  endtask

  task automatic new_op(input int i);
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    if ($urandom_range(3) == 0) a = 32'($urandom_range(15));
    b = ($urandom_range(3) == 0) ? a : $urandom;
    set_req(i, 4'($urandom_range(15)), a, b);
  endtask

  task automatic wait_hs(input int i);
    bit got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #1;
      if (hs[i]) got = 1'b1;
    end
    req_valid[i] = 1'b0;
    if (!got) bound_fail("handshake_timeout");
  endtask

  task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    set_req(i, op, a, b);
    wait_hs(i);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) bound_fail("idle_timeout");
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_random(input int ncyc, input int p_req, input int p_drop, input int p_rdy);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && hs[i]) begin
          if (int'($urandom_range(99)) < p_req) new_op(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if (int'($urandom_range(99)) < p_req) new_op(i);
        end else if (int'($urandom_range(99)) < p_drop) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = {(int'($urandom_range(99)) < p_rdy), (int'($urandom_range(99)) < p_rdy)};
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_idle();
  endtask

  initial begin
    do_reset();

    // Single add 5 + 7 from requester 0.
    rsp_ready = 2'b01;
    issue(0, 4'b0010, 32'd5, 32'd7);
    wait_idle();

    // Both requesters continuously valid, responses always accepted.
    run_random(30, 100, 0, 100);

    // Back-pressure: requester 1 subtract 9-9 held for 5 cycles while requester 0 waits.
    rsp_ready = 2'b00;
    issue(1, 4'b0110, 32'd9, 32'd9);
    set_req(0, 4'b0001, 32'h00F0, 32'h000F);
    repeat (5) @(posedge clk);
    #1 rsp_ready = 2'b10;
    wait_hs(0);
    rsp_ready = 2'b11;
    wait_idle();

    // Reset while the operation is in EXEC, then a normal request.
    rsp_ready = 2'b01;
    issue(0, 4'b0010, 32'd100, 32'd200);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 issue(0, 4'b0010, 32'd1, 32'd2);
    wait_idle();

    // Counter saturation on the 2-bit instance after a fresh reset.
    do_reset();
    rsp_ready = 2'b01;
    for (int n = 0; n < 5; n++) begin
      issue(0, 4'b0000, $urandom, $urandom);
      wait_idle();
    end

    // Unassigned opcode returns operand a.
    issue(0, 4'b1111, 32'hDEAD_BEEF, 32'd1);
    wait_idle();

    // Randomized traffic with varying pressure.
    run_random(600, 60, 5, 50);
    run_random(600, 90, 0, 90);
    run_random(600, 30, 20, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
